// File: rtl/imem_access_ctrl.sv
// Arbitrates the single-port instruction RAM between CPU fetch (read) and program loader (write).
// RUN shares the RAM with starvation-bounded fetch priority; LOAD hands it to the loader exclusively.
module imem_access_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_mode,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  output logic                  f_err,
  input  logic                  l_req,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_gnt,
  output logic                  l_drop,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  in_load
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rvalid_q, rerr_q;
  logic [31:0]   rdata_q;
  logic          f_win, l_win;
  logic          f_ok, l_ok, f_acc, l_acc;
  logic [31:0]   resp_data;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:DEPTH_LOG2+2] == '0);
  endfunction

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    f_win    = 1'b0;
    l_win    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (f_req && !(l_req && starve_q == SMAX)) f_win = 1'b1;
        else if (l_req)                            l_win = 1'b1;
        if (l_req && !l_win)
          starve_d = (starve_q == SMAX) ? starve_q : starve_q + SW'(1);
        else
          starve_d = '0;
        if (ld_mode) begin
          state_d  = S_LOAD;
          starve_d = '0;
        end
      end
      S_LOAD: begin
        l_win    = l_req;
        starve_d = '0;
        if (!ld_mode) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Grants are gated by rst_n so every combinational output is quiet during reset.
  assign f_ok   = addr_ok(f_addr);
  assign l_ok   = addr_ok(l_addr);
  assign f_gnt  = rst_n & f_win;
  assign l_gnt  = rst_n & l_win;
  assign f_acc  = f_gnt & f_ok;
  assign l_acc  = l_gnt & l_ok;
  assign l_drop = l_gnt & ~l_ok;

  assign mem_en    = f_acc | l_acc;
  assign mem_we    = l_acc;
  assign mem_wdata = l_acc ? l_wdata : 32'h0;
  assign mem_addr  = l_acc ? l_addr[DEPTH_LOG2+1:2] :
                     f_acc ? f_addr[DEPTH_LOG2+1:2] : '0;

  // RAM data arrives the cycle after the strobe; pass it through then, hold it afterwards.
  assign resp_data = rerr_q ? 32'h0 : mem_rdata;
  assign f_rvalid  = rvalid_q;
  assign f_err     = rvalid_q & rerr_q;
  assign f_rdata   = rvalid_q ? resp_data : rdata_q;
  assign in_load   = (state_q == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= f_gnt;
      if (f_gnt)    rerr_q  <= ~f_ok;
      if (rvalid_q) rdata_q <= resp_data;
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl: fetch expectations queued at grant, checked by a monitor.
module tb_imem_access_ctrl;

  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_mode, f_req, l_req;
  logic [31:0]   f_addr, l_addr, l_wdata;
  logic          f_gnt, f_rvalid, f_err, l_gnt, l_drop;
  logic [31:0]   f_rdata;
  logic          mem_en, mem_we;
  logic [DL-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          in_load;

  imem_access_ctrl #(.DEPTH_LOG2(DL), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_mode(ld_mode),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_drop(l_drop),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .in_load(in_load)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:(1<<DL)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.at   = cyc + 1;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (f_rvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'(f_rvalid), 32'h0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("rdata", f_rdata, x.data);
        chk("rerr", 32'(f_err), 32'(x.err));
        chk("rlatency", cyc, x.at);
      end
    end
  end

  // Called just after a rising edge; returns just after the rising edge that ends the grant cycle.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    bit got = 0;
    f_req  = 1'b1;
    f_addr = a;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (f_gnt) begin
        got = 1;
        chk("fetch_mem_en", 32'(mem_en), 32'(!e));
        push(d, e);
      end
    end
    if (!got) chk("fetch_grant_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1<<DL); i++) ram[i] = 32'h0;
    ram[0] = 32'h11;
    ram[1] = 32'h22;
    ram[2] = 32'h33;

    rst_n = 1'b0; ld_mode = 1'b0;
    f_req = 1'b1; l_req = 1'b1;
    f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_f_gnt", 32'(f_gnt), 32'h0);
    chk("rst_l_gnt", 32'(l_gnt), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_in_load", 32'(in_load), 32'h0);
    @(posedge clk); #1;
    f_req = 1'b0; l_req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(f_rvalid), 32'h0);
    chk("post_rst_rdata", f_rdata, 32'h0);
    chk("post_rst_err", 32'(f_err), 32'h0);
    @(posedge clk); #1;

    // Back-to-back fetches
    do_fetch(32'h0, 32'h11, 1'b0);
    do_fetch(32'h4, 32'h22, 1'b0);
    do_fetch(32'h8, 32'h33, 1'b0);
    f_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_rvalid", 32'(f_rvalid), 32'h0);
    chk("hold_rdata", f_rdata, 32'h33);
    @(posedge clk); #1;

    // Misaligned and out-of-range fetches
    do_fetch(32'h2, 32'h0, 1'b1);
    do_fetch(32'h1000, 32'h0, 1'b1);
    f_req = 1'b0;
    @(posedge clk); #1;

    // Loader write to bad address is dropped
    l_req = 1'b1; l_addr = 32'hFFFF_FFF0; l_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("drop_l_gnt", 32'(l_gnt), 32'h1);
    chk("drop_l_drop", 32'(l_drop), 32'h1);
    chk("drop_mem_en", 32'(mem_en), 32'h0);
    @(posedge clk); #1;
    l_req = 1'b0;
    @(posedge clk); #1;

    // Contention: four fetch grants then one loader grant, repeating
    f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b1; l_addr = 32'h100; l_wdata = 32'h5A5A_5A5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_f_gnt", 32'(f_gnt), 32'((i % 5) != 4));
      chk("starve_l_gnt", 32'(l_gnt), 32'((i % 5) == 4));
      if (f_gnt) push(32'h11, 1'b0);
      if (l_gnt) begin
        chk("starve_mem_we", 32'(mem_we), 32'h1);
        chk("starve_mem_addr", 32'(mem_addr), 32'h40);
      end
      @(posedge clk); #1;
    end
    f_req = 1'b0; l_req = 1'b0;
    @(posedge clk); #1;

    // LOAD mode; fetch granted on the entry cycle still returns
    ld_mode = 1'b1;
    do_fetch(32'h8, 32'h33, 1'b0);
    f_addr = 32'h10;
    l_req = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("load_in_load", 32'(in_load), 32'h1);
    chk("load_f_gnt", 32'(f_gnt), 32'h0);
    chk("load_l_gnt", 32'(l_gnt), 32'h1);
    chk("load_mem_we", 32'(mem_we), 32'h1);
    chk("load_mem_addr", 32'(mem_addr), 32'h4);
    chk("load_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    l_req = 1'b0; ld_mode = 1'b0;
    @(negedge clk);
    chk("load_exit_f_gnt", 32'(f_gnt), 32'h0);
    chk("load_exit_in_load", 32'(in_load), 32'h1);
    @(posedge clk); #1;
    chk("run_in_load", 32'(in_load), 32'h0);
    do_fetch(32'h10, 32'hDEAD_BEEF, 1'b0);
    f_req = 1'b0;
    @(posedge clk); #1;

    // Reset the cycle after a fetch grant (also entering LOAD)
    ld_mode = 1'b1;
    do_fetch(32'h4, 32'h22, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(f_rvalid), 32'h0);
    chk("mid_rst_rdata", f_rdata, 32'h0);
    chk("mid_rst_f_gnt", 32'(f_gnt), 32'h0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'h0);
    chk("mid_rst_in_load", 32'(in_load), 32'h0);
    @(posedge clk); #1;
    f_req = 1'b0; ld_mode = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_in_load", 32'(in_load), 32'h0);
    @(posedge clk); #1;
    do_fetch(32'h4, 32'h22, 1'b0);
    f_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
